// File: rtl/ntt_pkg.sv
// Shared types, default geometry and helpers for the NTT output serializer.
// Holds the bank/state enums, coefficient type and the bit-reverse function.
package ntt_pkg;

   localparam int DEF_DATA_WIDTH      = 28;
   localparam int DEF_INPUT_PER_CYCLE = 64;
   localparam int DEF_POLY_DEGREE     = 1024;

   localparam int VECTORS = DEF_POLY_DEGREE / DEF_INPUT_PER_CYCLE;
   localparam int IDX_W   = $clog2(DEF_POLY_DEGREE);
   localparam int VEC_W   = (VECTORS > 1) ? $clog2(VECTORS) : 1;
   localparam int LANE_W  =
      (DEF_INPUT_PER_CYCLE > 1) ? $clog2(DEF_INPUT_PER_CYCLE) : 1;

   typedef logic [DEF_DATA_WIDTH-1:0] coeff_t;

   typedef enum logic {
      W_IDLE,
      W_CAPTURE
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_STREAM
   } rd_state_t;

   // Reverse the low w bits of idx; upper bits of the result are zero.
   function automatic logic [31:0] bitrev(
      input logic [31:0] idx,
      input int unsigned w
   );
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < int'(w)) r[int'(w) - 1 - i] = idx[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/ntt_pingpong_bank.sv
// One ping-pong bank: a full polynomial of NV rows x IPC coefficients.
// Ports: clk; we/wrow/wdata write one whole row; rrow/rlane -> rdata (async).
module ntt_pingpong_bank #(
   parameter int DW  = 28,
   parameter int IPC = 64,
   parameter int NV  = 16,
   parameter int VW  = 4,
   parameter int LW  = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [VW-1:0] wrow,
   input  logic [DW-1:0] wdata [IPC],
   input  logic [VW-1:0] rrow,
   input  logic [LW-1:0] rlane,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [NV][IPC];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int l = 0; l < IPC; l++) begin
            mem[wrow][l] <= wdata[l];
         end
      end
   end

   assign rdata = mem[rrow][rlane];

endmodule

// File: rtl/ntt_output_serializer.sv
// Captures whole polynomials from the wide NTT output into two banks and
// streams them one coefficient per beat over valid/ready.
// Ports: clk, rst (sync, high); in_start/in_data capture side;
// out_valid/out_ready/out_data/out_last stream side; overflow (sticky drop).
// Build option: NTT_OUTPUT_SERIALIZER_BITREV_EN emits beat k from
// coefficient bitrev(k), turning bit-reversed NTT output into natural order.
module ntt_output_serializer
   import ntt_pkg::*;
#(
   parameter int DATA_WIDTH_PER_INPUT = DEF_DATA_WIDTH,
   parameter int INPUT_PER_CYCLE      = DEF_INPUT_PER_CYCLE,
   parameter int POLY_DEGREE          = DEF_POLY_DEGREE
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_start,
   input  logic [DATA_WIDTH_PER_INPUT-1:0] in_data [INPUT_PER_CYCLE],
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_WIDTH_PER_INPUT-1:0] out_data,
   output logic                            out_last,
   output logic                            overflow
);

   localparam int DW  = DATA_WIDTH_PER_INPUT;
   localparam int IPC = INPUT_PER_CYCLE;
   localparam int NV  = POLY_DEGREE / INPUT_PER_CYCLE;
   localparam int IW  = $clog2(POLY_DEGREE);
   localparam int VW  = (NV > 1) ? $clog2(NV) : 1;
   localparam int LW  = (IPC > 1) ? $clog2(IPC) : 1;

   localparam logic [IW-1:0] K_LAST = IW'(POLY_DEGREE - 1);

   // Source coefficient for output beat k.
   function automatic logic [IW-1:0] src_idx(input logic [IW-1:0] k);
`ifdef NTT_OUTPUT_SERIALIZER_BITREV_EN
      return IW'(bitrev(32'(k), IW));
`else
      return k;
`endif
   endfunction

   // Write side state
   wr_state_t     wr_state_q, wr_state_d;
   logic [VW-1:0] vcnt_q, vcnt_d;
   logic [VW-1:0] drop_q, drop_d;
   logic          wr_ptr_q, wr_ptr_d;
   logic          overflow_q, overflow_d;
   logic          wr_en;
   logic [VW-1:0] wr_row;
   logic          set_full;

   // Shared bank status
   logic [1:0]    full_q, full_d;

   // Read side state
   rd_state_t     rd_state_q, rd_state_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic [IW-1:0] k_q, k_d;
   logic          valid_q, valid_d;
   logic          last_q, last_d;
   logic [DW-1:0] data_q, data_d;
   logic          load;
   logic          ld_bank;
   logic [IW-1:0] ld_k;
   logic          release_bank;

   // Bank ports
   logic [IW-1:0] rd_src;
   logic [VW-1:0] rd_row;
   logic [LW-1:0] rd_lane;
   logic [DW-1:0] rdata0, rdata1;
   logic [DW-1:0] rd_word;

   // Registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q <= W_IDLE;
         vcnt_q     <= '0;
         drop_q     <= '0;
         wr_ptr_q   <= 1'b0;
         overflow_q <= 1'b0;
         full_q     <= '0;
         rd_state_q <= R_IDLE;
         rd_ptr_q   <= 1'b0;
         k_q        <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         data_q     <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         vcnt_q     <= vcnt_d;
         drop_q     <= drop_d;
         wr_ptr_q   <= wr_ptr_d;
         overflow_q <= overflow_d;
         full_q     <= full_d;
         rd_state_q <= rd_state_d;
         rd_ptr_q   <= rd_ptr_d;
         k_q        <= k_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         data_q     <= data_d;
      end
   end

   // Write FSM. A rejected start opens a drop window covering the rest
   // of that polynomial's vectors; starts seen inside it are also lost.
   always_comb begin
      wr_state_d = wr_state_q;
      vcnt_d     = vcnt_q;
      drop_d     = drop_q;
      wr_ptr_d   = wr_ptr_q;
      overflow_d = overflow_q;
      wr_en      = 1'b0;
      wr_row     = vcnt_q;
      set_full   = 1'b0;
      unique case (wr_state_q)
         W_IDLE: begin
            if (drop_q != '0) begin
               drop_d = drop_q - 1'b1;
               if (in_start) overflow_d = 1'b1;
            end else if (in_start) begin
               if (!full_q[wr_ptr_q]) begin
                  wr_en  = 1'b1;
                  wr_row = '0;
                  if (NV == 1) begin
                     set_full = 1'b1;
                     wr_ptr_d = ~wr_ptr_q;
                  end else begin
                     vcnt_d     = VW'(1);
                     wr_state_d = W_CAPTURE;
                  end
               end else begin
                  overflow_d = 1'b1;
                  drop_d     = VW'(NV - 1);
               end
            end
         end
         W_CAPTURE: begin
            wr_en = 1'b1;
            if (in_start) overflow_d = 1'b1;
            if (vcnt_q == VW'(NV - 1)) begin
               set_full   = 1'b1;
               wr_ptr_d   = ~wr_ptr_q;
               vcnt_d     = '0;
               wr_state_d = W_IDLE;
            end else begin
               vcnt_d = vcnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Read FSM. Every output register update goes through "load", which
   // fetches beat ld_k from bank ld_bank in the same cycle.
   always_comb begin
      rd_state_d   = rd_state_q;
      rd_ptr_d     = rd_ptr_q;
      k_d          = k_q;
      valid_d      = valid_q;
      last_d       = last_q;
      data_d       = data_q;
      load         = 1'b0;
      ld_bank      = rd_ptr_q;
      ld_k         = '0;
      release_bank = 1'b0;
      unique case (rd_state_q)
         R_IDLE: begin
            if (full_q[rd_ptr_q]) begin
               load       = 1'b1;
               rd_state_d = R_STREAM;
            end
         end
         R_STREAM: begin
            if (out_ready) begin
               if (k_q == K_LAST) begin
                  release_bank = 1'b1;
                  rd_ptr_d     = ~rd_ptr_q;
                  // Other bank ready: chain into it without a bubble.
                  if (full_q[~rd_ptr_q]) begin
                     load    = 1'b1;
                     ld_bank = ~rd_ptr_q;
                  end else begin
                     valid_d    = 1'b0;
                     last_d     = 1'b0;
                     rd_state_d = R_IDLE;
                  end
               end else begin
                  load = 1'b1;
                  ld_k = k_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
      if (load) begin
         valid_d = 1'b1;
         k_d     = ld_k;
         data_d  = rd_word;
         last_d  = (ld_k == K_LAST);
      end
   end

   // Full flags: set by the writer, cleared by the reader. The two can
   // never target the same bank in one cycle.
   always_comb begin
      full_d = full_q;
      if (set_full) full_d[wr_ptr_q] = 1'b1;
      if (release_bank) full_d[rd_ptr_q] = 1'b0;
   end

   assign rd_src  = src_idx(ld_k);
   assign rd_row  = VW'(32'(rd_src) / IPC);
   assign rd_lane = LW'(32'(rd_src) % IPC);
   assign rd_word = ld_bank ? rdata1 : rdata0;

   ntt_pingpong_bank #(
      .DW  (DW),
      .IPC (IPC),
      .NV  (NV),
      .VW  (VW),
      .LW  (LW)
   ) u_bank0 (
      .clk   (clk),
      .we    (wr_en && !wr_ptr_q),
      .wrow  (wr_row),
      .wdata (in_data),
      .rrow  (rd_row),
      .rlane (rd_lane),
      .rdata (rdata0)
   );

   ntt_pingpong_bank #(
      .DW  (DW),
      .IPC (IPC),
      .NV  (NV),
      .VW  (VW),
      .LW  (LW)
   ) u_bank1 (
      .clk   (clk),
      .we    (wr_en && wr_ptr_q),
      .wrow  (wr_row),
      .wdata (in_data),
      .rrow  (rd_row),
      .rlane (rd_lane),
      .rdata (rdata1)
   );

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_last  = last_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_ntt_output_serializer.sv
// Directed/randomized bench for ntt_output_serializer.
// Expected streams come from a queue model of accepted polynomials.
module tb_ntt_output_serializer;

   localparam int DW  = 28;
   localparam int IPC = 64;
   localparam int N   = 1024;
   localparam int NV  = N / IPC;
   localparam int LOGN = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_start;
   logic [DW-1:0] in_data [IPC];
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          overflow;

   always #5 clk = ~clk;

   ntt_output_serializer dut (
      .clk       (clk),
      .rst       (rst),
      .in_start  (in_start),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .overflow  (overflow)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rdy_mode = 1;
   int first_cyc = 0;
   int last_cyc = 0;

   logic [DW-1:0] pm [4][N];
   logic [DW-1:0] got_d [$];
   logic          got_l [$];
   logic [DW-1:0] exp_d [$];
   logic          exp_l [$];

   logic          pv, pr, pl;
   logic [DW-1:0] pd;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int model_src(input int k);
      int r = 0;
`ifdef NTT_OUTPUT_SERIALIZER_BITREV_EN
      for (int i = 0; i < LOGN; i++) r = r | (((k >> i) & 1) << (LOGN - 1 - i));
`else
      r = k;
`endif
      return r;
   endfunction

   // One clock: record a handshake, advance, check stall stability.
   task automatic step();
      if (!rst && out_valid && out_ready) begin
         got_d.push_back(out_data);
         got_l.push_back(out_last);
         if (got_d.size() == 1) first_cyc = cyc;
         last_cyc = cyc;
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      pl = out_last;
      @(posedge clk);
      #1;
      cyc++;
      if (pv && !pr && !rst) begin
         chk("stall_valid", 64'(out_valid), 64'(1));
         chk("stall_data", 64'(out_data), 64'(pd));
         chk("stall_last", 64'(out_last), 64'(pl));
      end
      case (rdy_mode)
         0: out_ready = 1'b0;
         1: out_ready = 1'b1;
         2: out_ready = ~out_ready;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic fill_poly(input int pid, input int mode);
      for (int i = 0; i < N; i++) begin
         case (mode)
            0: pm[pid][i] = DW'(i);
            1: pm[pid][i] = DW'(i + 5000);
            default: pm[pid][i] = DW'($urandom);
         endcase
      end
   endtask

   task automatic drive_poly(input int pid, input int extra_at);
      for (int v = 0; v < NV; v++) begin
         in_start = (v == 0) || (v == extra_at);
         for (int l = 0; l < IPC; l++) in_data[l] = pm[pid][v * IPC + l];
         step();
      end
      in_start = 1'b0;
   endtask

   task automatic expect_poly(input int pid);
      for (int k = 0; k < N; k++) begin
         exp_d.push_back(pm[pid][model_src(k)]);
         exp_l.push_back(k == N - 1);
      end
   endtask

   task automatic drain(input string tag, input int n);
      int t = 0;
      while (got_d.size() < n && t < 6000) begin
         step();
         t++;
      end
      chk({tag, "_timeout"}, 64'(t < 6000), 64'(1));
      repeat (6) step();
      chk({tag, "_idle"}, 64'(out_valid), 64'(0));
   endtask

   task automatic compare(input string tag);
      int n;
      chk({tag, "_count"}, 64'(got_d.size()), 64'(exp_d.size()));
      n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_data[%0d]", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
         chk($sformatf("%s_last[%0d]", tag, i), 64'(got_l[i]), 64'(exp_l[i]));
      end
      got_d.delete();
      got_l.delete();
      exp_d.delete();
      exp_l.delete();
   endtask

   initial begin
      rst = 1'b1;
      in_start = 1'b0;
      out_ready = 1'b0;
      for (int l = 0; l < IPC; l++) in_data[l] = '0;
      rdy_mode = 1;
      repeat (3) step();
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_last", 64'(out_last), 64'(0));
      chk("rst_data", 64'(out_data), 64'(0));
      chk("rst_overflow", 64'(overflow), 64'(0));
      rst = 1'b0;
      step();

      // Single polynomial, data = index, latency check.
      fill_poly(0, 0);
      expect_poly(0);
      drive_poly(0, -1);
      chk("lat_not_yet", 64'(out_valid), 64'(0));
      step();
      chk("lat_valid_17", 64'(out_valid), 64'(1));
      chk("lat_first_data", 64'(out_data), 64'(pm[0][model_src(0)]));
      drain("single", N);
      compare("single");

      // Backpressure: toggling ready, random data.
      rdy_mode = 2;
      fill_poly(1, 2);
      expect_poly(1);
      drive_poly(1, -1);
      drain("bp", N);
      compare("bp");

      // Back-to-back with no bubble.
      rdy_mode = 1;
      fill_poly(0, 0);
      fill_poly(1, 1);
      expect_poly(0);
      expect_poly(1);
      drive_poly(0, -1);
      drive_poly(1, -1);
      drain("b2b", 2 * N);
      chk("b2b_contiguous", 64'(last_cyc - first_cyc), 64'(2 * N - 1));
      compare("b2b");

      // Overflow: third polynomial dropped while both banks are full.
      rdy_mode = 0;
      fill_poly(0, 2);
      fill_poly(1, 2);
      fill_poly(2, 2);
      expect_poly(0);
      expect_poly(1);
      drive_poly(0, -1);
      drive_poly(1, -1);
      chk("ovf_before", 64'(overflow), 64'(0));
      drive_poly(2, -1);
      chk("ovf_after", 64'(overflow), 64'(1));
      chk("ovf_held_valid", 64'(out_valid), 64'(1));
      rdy_mode = 3;
      drain("ovf", 2 * N);
      repeat (40) step();
      compare("ovf");

      // Reset clears overflow.
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst2_overflow", 64'(overflow), 64'(0));

      // Extra start pulse during capture.
      fill_poly(3, 2);
      expect_poly(3);
      drive_poly(3, 5);
      chk("mid_ovf", 64'(overflow), 64'(1));
      drain("mid", N);
      compare("mid");

      // Reset in the middle of streaming.
      rdy_mode = 1;
      fill_poly(0, 2);
      drive_poly(0, -1);
      begin
         int t = 0;
         while (got_d.size() < 300 && t < 3000) begin
            step();
            t++;
         end
         chk("mrst_reach300", 64'(t < 3000), 64'(1));
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_valid", 64'(out_valid), 64'(0));
      chk("mrst_overflow", 64'(overflow), 64'(0));
      got_d.delete();
      got_l.delete();
      repeat (30) step();
      chk("mrst_silent", 64'(got_d.size()), 64'(0));
      fill_poly(1, 2);
      expect_poly(1);
      drive_poly(1, -1);
      drain("mrst", N);
      compare("mrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
